// File: rtl/risc_pkg.sv
// Shared definitions for the 8-bit RISC sequencer: opcodes, sequencer states
// and the bundle of datapath strobes the controller drives.
package risc_pkg;

  localparam int unsigned OPCODE_W = 3;

  localparam logic [OPCODE_W-1:0] OP_HLT  = 3'b000;
  localparam logic [OPCODE_W-1:0] OP_SKZ  = 3'b001;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 3'b010;
  localparam logic [OPCODE_W-1:0] OP_ANDD = 3'b011;
  localparam logic [OPCODE_W-1:0] OP_XORR = 3'b100;
  localparam logic [OPCODE_W-1:0] OP_LDA  = 3'b101;
  localparam logic [OPCODE_W-1:0] OP_STO  = 3'b110;
  localparam logic [OPCODE_W-1:0] OP_JMP  = 3'b111;

  typedef enum logic [3:0] {
    S0, S1, S2, S3, S4, S5, S6, S7, HALTED
  } state_t;

  typedef struct packed {
    logic load_ir;
    logic inc_pc;
    logic load_pc;
    logic load_acc;
    logic rd;
    logic wr;
    logic datactl_ena;
    logic halt;
  } ctrl_t;

  // Instructions that read a memory operand into the ALU/accumulator
  function automatic logic is_mem_read_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_ADD) || (op == OP_ANDD) || (op == OP_XORR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/machine_ctrl.sv
// Instruction sequencer: 8-state fetch/decode/execute cycle producing registered
// datapath strobes decoded from the state being entered on each enabled edge.
module machine_ctrl
  import risc_pkg::*;
#(
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  output logic                load_ir,
  output logic                inc_pc,
  output logic                load_pc,
  output logic                load_acc,
  output logic                rd,
  output logic                wr,
  output logic                datactl_ena,
  output logic                halt
);

  state_t              state, state_nxt;
  logic                parked, parked_nxt;
  logic [OPCODE_W-1:0] op_q, op_nxt;
  logic                zero_q, zero_nxt;
  ctrl_t               out_q, out_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S0;
      parked <= 1'b1;
      op_q   <= '0;
      zero_q <= 1'b0;
      out_q  <= '0;
    end else begin
      state  <= state_nxt;
      parked <= parked_nxt;
      op_q   <= op_nxt;
      zero_q <= zero_nxt;
      out_q  <= out_nxt;
    end
  end

  // Parked S0 is distinct from an active S0: the first enabled edge after
  // reset or an ena gap enters S0 (fetch) instead of advancing to S1.
  always_comb begin
    state_nxt  = state;
    parked_nxt = parked;
    op_nxt     = op_q;
    zero_nxt   = zero_q;
    if (!ena) begin
      if (HALT_STICKY && (state == HALTED || out_q.halt)) begin
        state_nxt = HALTED;
      end else begin
        state_nxt  = S0;
        parked_nxt = 1'b1;
      end
    end else if (state == HALTED) begin
      state_nxt = HALTED;
    end else if (parked) begin
      state_nxt  = S0;
      parked_nxt = 1'b0;
    end else begin
      unique case (state)
        S0: state_nxt = S1;
        S1: state_nxt = S2;
        S2: begin
          state_nxt = S3;
          op_nxt    = opcode;
          zero_nxt  = zero;
        end
        S3:      state_nxt = (op_q == OP_HLT) ? HALTED : S4;
        S4:      state_nxt = S5;
        S5:      state_nxt = S6;
        S6:      state_nxt = S7;
        S7:      state_nxt = S0;
        default: state_nxt = S0;
      endcase
    end
  end

  always_comb begin
    out_nxt = '0;
    if (state_nxt == HALTED) begin
      out_nxt.halt = 1'b1;
    end else if (!parked_nxt) begin
      unique case (state_nxt)
        S0, S1: begin
          out_nxt.load_ir = 1'b1;
          out_nxt.rd      = 1'b1;
          out_nxt.inc_pc  = 1'b1;
        end
        S3: out_nxt.halt = (op_nxt == OP_HLT);
        S4: begin
          out_nxt.rd          = is_mem_read_op(op_nxt);
          out_nxt.datactl_ena = (op_nxt == OP_STO);
          out_nxt.load_pc     = (op_nxt == OP_JMP);
        end
        S5: begin
          out_nxt.rd          = is_mem_read_op(op_nxt);
          out_nxt.load_acc    = is_mem_read_op(op_nxt);
          out_nxt.datactl_ena = (op_nxt == OP_STO);
          out_nxt.wr          = (op_nxt == OP_STO);
          out_nxt.inc_pc      = (op_nxt == OP_SKZ) && zero_nxt;
          out_nxt.load_pc     = (op_nxt == OP_JMP);
        end
        S6: out_nxt.datactl_ena = (op_nxt == OP_STO);
        S7: out_nxt.inc_pc      = (op_nxt == OP_SKZ) && zero_nxt;
        default: out_nxt = '0;
      endcase
    end
  end

  assign load_ir     = out_q.load_ir;
  assign inc_pc      = out_q.inc_pc;
  assign load_pc     = out_q.load_pc;
  assign load_acc    = out_q.load_acc;
  assign rd          = out_q.rd;
  assign wr          = out_q.wr;
  assign datactl_ena = out_q.datactl_ena;
  assign halt        = out_q.halt;

endmodule

// File: tb/tb_machine_ctrl.sv
// Scoreboard bench for machine_ctrl: sticky and non-sticky halt variants run in
// lockstep against an instruction-position reference model.
module tb_machine_ctrl;

  typedef struct packed {
    logic load_ir;
    logic inc_pc;
    logic load_pc;
    logic load_acc;
    logic rd;
    logic wr;
    logic datactl_ena;
    logic halt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic       zero = 1'b0;

  vec_t act [2];

  always #5 clk = ~clk;

  machine_ctrl #(.HALT_STICKY(1'b1)) u_sticky (
    .clk(clk), .rst(rst), .ena(ena), .opcode(opcode), .zero(zero),
    .load_ir(act[0].load_ir), .inc_pc(act[0].inc_pc), .load_pc(act[0].load_pc),
    .load_acc(act[0].load_acc), .rd(act[0].rd), .wr(act[0].wr),
    .datactl_ena(act[0].datactl_ena), .halt(act[0].halt)
  );

  machine_ctrl #(.HALT_STICKY(1'b0)) u_plain (
    .clk(clk), .rst(rst), .ena(ena), .opcode(opcode), .zero(zero),
    .load_ir(act[1].load_ir), .inc_pc(act[1].inc_pc), .load_pc(act[1].load_pc),
    .load_acc(act[1].load_acc), .rd(act[1].rd), .wr(act[1].wr),
    .datactl_ena(act[1].datactl_ena), .halt(act[1].halt)
  );

  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, ANDD = 3'd3,
                         XORR = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  vec_t exp_q0 [$];
  vec_t exp_q1 [$];

  // Model: position within the 8-cycle instruction (-1 = parked) plus halt flag
  int         pos    [2] = '{-1, -1};
  bit         halted [2] = '{1'b0, 1'b0};
  logic [2:0] op_l   [2];
  logic       z_l    [2];

  function automatic vec_t expect_at(input int p, input logic [2:0] op, input logic z);
    vec_t v = '0;
    bit   alu = (op == ADD) || (op == ANDD) || (op == XORR) || (op == LDA);
    case (p)
      0, 1: begin v.load_ir = 1; v.rd = 1; v.inc_pc = 1; end
      3: v.halt = (op == HLT);
      4: begin v.rd = alu; v.datactl_ena = (op == STO); v.load_pc = (op == JMP); end
      5: begin
        v.rd = alu; v.load_acc = alu;
        v.datactl_ena = (op == STO); v.wr = (op == STO);
        v.inc_pc = (op == SKZ) && z; v.load_pc = (op == JMP);
      end
      6: v.datactl_ena = (op == STO);
      7: v.inc_pc = (op == SKZ) && z;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model_step(input int m, input bit sticky, input logic r, input logic e,
                            input logic [2:0] op, input logic z, output vec_t v);
    v = '0;
    if (r) begin
      pos[m] = -1; halted[m] = 0;
    end else if (!e) begin
      if (halted[m] && sticky) v.halt = 1;
      else begin pos[m] = -1; halted[m] = 0; end
    end else if (halted[m]) begin
      v.halt = 1;
    end else begin
      pos[m] = (pos[m] < 0) ? 0 : (pos[m] + 1) % 8;
      if (pos[m] == 3) begin op_l[m] = op; z_l[m] = z; end
      v = expect_at(pos[m], op_l[m], z_l[m]);
      if (pos[m] == 3 && op_l[m] == HLT) halted[m] = 1;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [2:0] op, input logic z);
    vec_t v0, v1;
    rst = r; ena = e; opcode = op; zero = z;
    model_step(0, 1'b1, r, e, op, z, v0);
    model_step(1, 1'b0, r, e, op, z, v1);
    @(posedge clk);
    exp_q0.push_back(v0);
    exp_q1.push_back(v1);
    #1;
  endtask

  task automatic check(input string name, input vec_t got, input vec_t want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%b required=%b (ir,inc,ldpc,ldacc,rd,wr,dena,halt)",
               name, cyc, got, want);
    end
    if ((got.rd && got.wr) || (got.wr && !got.datactl_ena)) begin
      miscompares++;
      $display("FAIL %s_rdwr cyc=%0d got rd=%b wr=%b dena=%b required wr only with dena, never with rd",
               name, cyc, got.rd, got.wr, got.datactl_ena);
    end
  endtask

  initial begin
    vec_t w;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q0.size() > 0) begin w = exp_q0.pop_front(); check("sticky", act[0], w); end
      if (exp_q1.size() > 0) begin w = exp_q1.pop_front(); check("plain", act[1], w); end
    end
  end

  initial begin
    repeat (2) step(1, 0, HLT, 0);
    repeat (8) step(0, 1, LDA, 0);
    repeat (8) step(0, 1, STO, 0);
    repeat (8) step(0, 1, SKZ, 1);
    repeat (8) step(0, 1, SKZ, 0);
    repeat (4) step(0, 1, HLT, 0);
    repeat (20) step(0, 1, HLT, 0);
    step(1, 1, HLT, 0);
    repeat (5) step(0, 1, JMP, 0);
    step(0, 0, JMP, 0);
    repeat (3) step(0, 1, JMP, 0);
    step(1, 0, ADD, 0);
    repeat (5) step(0, 1, ADD, 0);
    step(1, 1, ADD, 0);
    repeat (8) step(0, 1, ADD, 0);
    // halt, then drop ena: sticky variant stays halted, plain variant restarts
    step(1, 0, HLT, 0);
    repeat (6) step(0, 1, HLT, 0);
    repeat (2) step(0, 0, HLT, 0);
    repeat (4) step(0, 1, ADD, 0);
    for (int i = 0; i < 3000; i++) begin
      logic r, e;
      r = ($urandom_range(0, 63) == 0) || (halted[0] && $urandom_range(0, 7) == 0);
      e = ($urandom_range(0, 15) != 0);
      step(r, e, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
    repeat (3) @(posedge clk);
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      miscompares++;
      $display("FAIL drain got=%0d/%0d pending required=0", exp_q0.size(), exp_q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
